// File: rtl/alu_issue_sequencer_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, FSM states,
// instruction-register field positions and opcode classification helpers.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,
    OP_STORE = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_NOT   = 4'd7,
    OP_SLL   = 4'd8,
    OP_SRL   = 4'd9,
    OP_BEQZ  = 4'd10,
    OP_BNEZ  = 4'd11,
    OP_JUMP  = 4'd12
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_MEM,
    S_WB,
    S_NEXT,
    S_HALT
  } state_e;

  localparam int IR_OP_LSB  = 12;
  localparam int IR_RS_LSB  = 9;
  localparam int IR_RT_LSB  = 6;
  localparam int IR_OFF_LSB = 0;
  localparam int IR_OFF_W   = 6;
  localparam int IR_TGT_W   = 12;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_JUMP);
  endfunction

  function automatic logic is_ldst(input logic [3:0] op);
    return op <= OP_STORE;
  endfunction

  function automatic logic writes_reg(input logic [3:0] op);
    return (op == OP_LOAD) || ((op >= OP_ADD) && (op <= OP_SRL));
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: jump keeps the 4 KiW page, branch adds a signed
// 6-bit offset to pc+1, everything else is sequential (all modulo 2^16).
module pc_next_calc
  import alu_seq_pkg::*;
(
  input  logic [15:0]         pc_i,
  input  logic [IR_TGT_W-1:0] tgt_i,
  input  logic                br_sel_i,
  input  logic                jmp_sel_i,
  output logic [15:0]         pc_next_o
);

  logic [15:0] seq_pc;
  logic [15:0] off_sext;

  always_comb begin
    seq_pc   = pc_i + 16'd1;
    off_sext = {{(16 - IR_OFF_W){tgt_i[IR_OFF_LSB + IR_OFF_W - 1]}},
                tgt_i[IR_OFF_LSB +: IR_OFF_W]};
    if (jmp_sel_i) begin
      pc_next_o = {pc_i[15:IR_TGT_W], tgt_i};
    end else if (br_sel_i) begin
      pc_next_o = seq_pc + off_sext;
    end else begin
      pc_next_o = seq_pc;
    end
  end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Instruction issue FSM driving the ALU strobe/flag handshake of the 16-bit core.
// Build option ILLEGAL_HALT_EN: illegal opcodes park the FSM in HALT until rst.
module alu_issue_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned MEM_LAT     = 2,
  parameter int unsigned ALU_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic        isALUFinished,
  input  logic        execute_branch,
  input  logic        jump_flag,
  output logic [15:0] pc,
  output logic [3:0]  opcode,
  output logic [2:0]  rs_addr,
  output logic [2:0]  rt_addr,
  output logic [5:0]  offset,
  output logic        isALUOP,
  output logic        isLoadStore,
  output logic        memRead,
  output logic        memWrite,
  output logic        reg_write,
  output logic [2:0]  wr_addr,
  output logic        wb_sel,
  output logic        fetchNextInst,
  output logic        alu_timeout,
  output logic        illegal_op,
  output logic        halted
);

  localparam logic [7:0] TO_LIMIT = 8'(ALU_TIMEOUT);
  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, pc_calc;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  timer_q, timer_d;
  logic [3:0]  mem_cnt_q, mem_cnt_d;
  logic        br_sel_q, br_sel_d, jmp_sel_q, jmp_sel_d;
  logic        alu_to_q, alu_to_d, illegal_q, illegal_d;
  logic        isalu_q, isalu_d, isls_q, isls_d;
  logic        mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic        reg_wr_q, reg_wr_d, fni_q, fni_d;
  logic [2:0]  wr_addr_q, wr_addr_d;
  logic        wb_sel_q, wb_sel_d;

  logic [3:0]  op;
  logic        any_flag;

  assign op       = ir_q[IR_OP_LSB +: 4];
  assign any_flag = isALUFinished | execute_branch | jump_flag;

  pc_next_calc u_pc_next (
    .pc_i      (pc_q),
    .tgt_i     (ir_q[IR_TGT_W-1:0]),
    .br_sel_i  (br_sel_q),
    .jmp_sel_i (jmp_sel_q),
    .pc_next_o (pc_calc)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    timer_d   = timer_q;
    mem_cnt_d = mem_cnt_q;
    br_sel_d  = br_sel_q;
    jmp_sel_d = jmp_sel_q;
    alu_to_d  = alu_to_q;
    illegal_d = illegal_q;
    wr_addr_d = wr_addr_q;
    wb_sel_d  = wb_sel_q;

    unique case (state_q)
      S_FETCH: begin
        // Stale flags mean the ALU never saw fetchNextInst; give up eventually.
        if (!any_flag || (timer_q >= TO_LIMIT)) begin
          alu_to_d = alu_to_q | any_flag;
          ir_d     = instr_in;
          timer_d  = 8'd0;
          state_d  = S_DECODE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_DECODE: begin
        br_sel_d  = 1'b0;
        jmp_sel_d = 1'b0;
        timer_d   = 8'd0;
        if (is_alu_op(op) || is_ldst(op)) begin
          state_d = S_ISSUE;
        end else begin
          illegal_d = 1'b1;
`ifdef ILLEGAL_HALT_EN
          state_d   = S_HALT;
`else
          state_d   = S_NEXT;
`endif
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (jump_flag) begin
          jmp_sel_d = 1'b1;
          state_d   = S_NEXT;
        end else if (execute_branch) begin
          br_sel_d = 1'b1;
          state_d  = S_NEXT;
        end else if (isALUFinished) begin
          mem_cnt_d = 4'd0;
          if (is_ldst(op))          state_d = S_MEM;
          else if (writes_reg(op))  state_d = S_WB;
          else                      state_d = S_NEXT;
        end else if (timer_q == TO_LIMIT - 8'd1) begin
          alu_to_d = 1'b1;
          state_d  = S_NEXT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_MEM: begin
        if (mem_cnt_q == MEM_LAST) begin
          state_d = (op == OP_LOAD) ? S_WB : S_NEXT;
        end else begin
          mem_cnt_d = mem_cnt_q + 4'd1;
        end
      end
      S_WB:   state_d = S_NEXT;
      S_NEXT: begin
        pc_d    = pc_calc;
        timer_d = 8'd0;
        state_d = S_FETCH;
      end
`ifdef ILLEGAL_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase

    if (state_d == S_WB) begin
      wr_addr_d = (op == OP_LOAD) ? ir_q[IR_RT_LSB +: 3] : ir_q[IR_RS_LSB +: 3];
      wb_sel_d  = (op == OP_LOAD);
    end

    // Strobes are decoded from the next state so they leave a flop cleanly.
    isalu_d  = (state_d == S_ISSUE) && is_alu_op(op);
    isls_d   = (state_d == S_ISSUE) && is_ldst(op);
    mem_rd_d = (state_d == S_MEM) && (op == OP_LOAD);
    mem_wr_d = (state_d == S_MEM) && (op == OP_STORE);
    reg_wr_d = (state_d == S_WB);
    fni_d    = (state_d == S_NEXT);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      timer_q   <= 8'd0;
      mem_cnt_q <= 4'd0;
      br_sel_q  <= 1'b0;
      jmp_sel_q <= 1'b0;
      alu_to_q  <= 1'b0;
      illegal_q <= 1'b0;
      isalu_q   <= 1'b0;
      isls_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      reg_wr_q  <= 1'b0;
      fni_q     <= 1'b0;
      wr_addr_q <= 3'd0;
      wb_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      timer_q   <= timer_d;
      mem_cnt_q <= mem_cnt_d;
      br_sel_q  <= br_sel_d;
      jmp_sel_q <= jmp_sel_d;
      alu_to_q  <= alu_to_d;
      illegal_q <= illegal_d;
      isalu_q   <= isalu_d;
      isls_q    <= isls_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      reg_wr_q  <= reg_wr_d;
      fni_q     <= fni_d;
      wr_addr_q <= wr_addr_d;
      wb_sel_q  <= wb_sel_d;
    end
  end

  assign pc            = pc_q;
  assign opcode        = op;
  assign rs_addr       = ir_q[IR_RS_LSB +: 3];
  assign rt_addr       = ir_q[IR_RT_LSB +: 3];
  assign offset        = ir_q[IR_OFF_LSB +: IR_OFF_W];
  assign isALUOP       = isalu_q;
  assign isLoadStore   = isls_q;
  assign memRead       = mem_rd_q;
  assign memWrite      = mem_wr_q;
  assign reg_write     = reg_wr_q;
  assign wr_addr       = wr_addr_q;
  assign wb_sel        = wb_sel_q;
  assign fetchNextInst = fni_q;
  assign alu_timeout   = alu_to_q;
  assign illegal_op    = illegal_q;

`ifdef ILLEGAL_HALT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
